mult_share_arb: RTL and testbench
=================================

Name: mult_share_arb

Overview:
- Shares one 3-lane pipelined unsigned 6x8 multiplier among NREQ requesters, e.g. CLAHE interpolation weight x LUT value stages.
- Grants one request per cycle using round-robin arbitration and drives the multiplier operands, clock enable and input valid.
- Carries a requester tag through a PIPE-deep shadow pipeline and returns each 3x14-bit product to its originator.
- Downstream backpressure stalls the whole multiplier pipeline through its clock enable.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PIPE, 4, multiplier pipeline latency in cycles; must match the attached multiplier.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  NREQ  request present, per requester.
- req_ready  out  NREQ  request accepted this cycle.
- req_a  in  NREQ*18  per requester, 3 lanes x 6-bit weight; requester i occupies bits [18i+17:18i].
- req_b  in  NREQ*24  per requester, 3 lanes x 8-bit value; requester i occupies bits [24i+23:24i].
- resp_valid  out  NREQ  result for requester i is on resp_data.
- resp_ready  in  NREQ  requester i accepts the result.
- resp_data  out  42  3 lanes x 14-bit product, shared by all requesters.
- m_clk_en  out  1  multiplier clock enable.
- m_in_valid  out  1  multiplier input valid.
- m_dataa  out  18  multiplier operand A.
- m_datab  out  24  multiplier operand B.
- m_data  in  42  multiplier result.
- m_valid  in  1  multiplier output valid.
- busy  out  1  at least one operation in flight.
- err  out  1  sticky error: m_valid disagrees with the internal tag valid.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. During reset:
  - tag valid bits clear; tag ids 0;
  - RR pointer = NREQ-1, so requester 0 has first priority;
  - err=0, busy=0, all resp_valid=0, m_in_valid=0, m_clk_en=1.
  - The multiplier shares rst_n, so in-flight operations are discarded on reset, including reset mid-operation.
- Shadow pipeline: tv[0..PIPE-1] (valid) and tid[0..PIPE-1] (id, clog2(NREQ) bits). It shifts only when m_clk_en=1: tv[0] takes the grant flag, tid[0] takes the grant index.
- Stall rule (combinational): stall = tv[PIPE-1] & ~resp_ready[tid[PIPE-1]]; m_clk_en = ~stall.
- Arbitration (combinational, round-robin):
  - The winner is the first requester with req_valid=1, searching from pointer+1 upward with wrap.
  - A grant happens only when m_clk_en=1.
  - req_ready = one-hot of the winner (at most one bit set), all zeros while stalled.
  - Pointer updates to the winner on each grant; it is unchanged with no grant.
- Operand mux: m_dataa/m_datab = the winner's req_a/req_b slice; all zeros with no grant. m_in_valid = grant.
- Response: resp_valid[i] = tv[PIPE-1] & (tid[PIPE-1]==i). resp_data = m_data passed through unmodified. The multiplier holds m_data while m_clk_en=0, so a stalled result stays stable until accepted.
- Retirement: a result retires on the cycle resp_ready of the owner is high. Because the pipeline advances on that same cycle, back-to-back results are supported.
- Latency: accepted at cycle T; resp_valid rises at T+PIPE plus the number of stall cycles. Throughput is 1 op/cycle.
- No request is lost or duplicated. Ordering is global FIFO.
- busy = OR of tv.
- err: set when m_clk_en=1 & (m_valid != tv[PIPE-1]); cleared only by reset.
- Simultaneous retire-stall-and-new-request: while stalled, no grant is made; requesters hold req_valid; the request is granted on the first unstalled cycle.
- Width rule: each 6x8 unsigned lane product fits 14 bits exactly (max 63*255 = 16065); no truncation.

Test Plan:
- Single op, PIPE=4: requester 1 sends lanes a={63,1,0}, b={255,10,7} at cycle T.
  -> req_ready[1]=1 at T; resp_valid[1]=1 at T+4; resp_data lanes = {16065,10,0}; busy high from T+1 to T+4.
- Round-robin: all 4 requesters hold req_valid continuously from reset.
  -> grant order 0,1,2,3,0,1; one grant per cycle; each requester receives its own products with the correct tids.
- Backpressure: stream from requester 2; resp_ready[2] held low for 3 cycles while its result is at the output.
  -> m_clk_en=0 and req_ready=0 for 3 cycles; resp_data held stable; after release, results resume in order with no loss or duplication.
- Sparse and mixed traffic: requesters 0 and 3 request alternately with idle gaps.
  -> bubbles give m_in_valid=0; the pointer skips idle requesters; err stays 0.
- Reset mid-operation: assert rst_n low with 3 ops in flight.
  -> all resp_valid=0 immediately (asynchronous); after release busy=0, pointer back to its reset value, no stale results emerge.
- Error check: force m_valid=1 while the pipeline is empty.
  -> err=1 the next cycle and remains set until reset.

Source files
------------

// File: rtl/mult_share_arb.sv
// Round-robin share of one PIPE-deep 3-lane 6x8 multiplier among NREQ requesters, with a tag shadow pipe routing products home.
// Latency PIPE cycles plus stall cycles; an unaccepted result freezes the whole multiplier through m_clk_en.
module mult_share_arb #(
   parameter int NREQ = 4,
   parameter int PIPE = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*18-1:0]   req_a,
   input  logic [NREQ*24-1:0]   req_b,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [41:0]          resp_data,
   output logic                 m_clk_en,
   output logic                 m_in_valid,
   output logic [17:0]          m_dataa,
   output logic [23:0]          m_datab,
   input  logic [41:0]          m_data,
   input  logic                 m_valid,
   output logic                 busy,
   output logic                 err
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef logic [IDW-1:0] id_t;

   logic [PIPE-1:0]          tv_q, tv_d;
   logic [PIPE-1:0][IDW-1:0] tid_q, tid_d;
   id_t                      ptr_q, ptr_d;
   logic                     err_q, err_d;
   logic                     stall;
   logic                     grant;
   id_t                      win;
   id_t                      out_id;

   assign out_id   = tid_q[PIPE-1];
   assign stall    = tv_q[PIPE-1] & ~resp_ready[out_id];
   assign m_clk_en = ~stall;

   // Search starts one past the last winner so every requester gets a turn.
   always_comb begin : arb
      int   idx;
      logic hit;
      idx = 0;
      hit = 1'b0;
      win = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!hit && req_valid[idx]) begin
            hit = 1'b1;
            win = id_t'(idx);
         end
      end
      // rst_n gating keeps the multiplier input idle while reset is held.
      grant = hit & m_clk_en & rst_n;
   end

   always_comb begin
      req_ready = '0;
      m_dataa   = '0;
      m_datab   = '0;
      if (grant) begin
         req_ready[win] = 1'b1;
         m_dataa        = req_a[int'(win)*18 +: 18];
         m_datab        = req_b[int'(win)*24 +: 24];
      end
   end

   assign m_in_valid = grant;
   assign ptr_d      = grant ? win : ptr_q;

   always_comb begin
      tv_d  = tv_q;
      tid_d = tid_q;
      if (m_clk_en) begin
         for (int i = PIPE-1; i > 0; i--) begin
            tv_d[i]  = tv_q[i-1];
            tid_d[i] = tid_q[i-1];
         end
         tv_d[0]  = grant;
         tid_d[0] = win;
      end
   end

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < NREQ; i++) begin
         resp_valid[i] = tv_q[PIPE-1] && (out_id == id_t'(i));
      end
   end

   assign resp_data = m_data;
   assign busy      = |tv_q;
   assign err_d     = err_q | (m_clk_en & (m_valid != tv_q[PIPE-1]));
   assign err       = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tv_q  <= '0;
         tid_q <= '0;
         ptr_q <= id_t'(NREQ-1);
         err_q <= 1'b0;
      end else begin
         tv_q  <= tv_d;
         tid_q <= tid_d;
         ptr_q <= ptr_d;
         err_q <= err_d;
      end
   end
endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural PIPE-deep multiplier attached.
module tb_mult_share_arb;
   localparam int NREQ = 4;
   localparam int PIPE = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*18-1:0]   req_a;
   logic [NREQ*24-1:0]   req_b;
   logic [NREQ-1:0]      resp_valid;
   logic [NREQ-1:0]      resp_ready;
   logic [41:0]          resp_data;
   logic                 m_clk_en;
   logic                 m_in_valid;
   logic [17:0]          m_dataa;
   logic [23:0]          m_datab;
   logic [41:0]          m_data;
   logic                 m_valid;
   logic                 busy;
   logic                 err;

   logic                 force_mv;
   logic [7:0]           b2;
   logic [17:0]          opa [NREQ];
   logic [23:0]          opb [NREQ];
   int                   nvec = 0;
   int                   nmis = 0;
   int                   cur  = 0;

   always #5 clk = ~clk;

   mult_share_arb #(.NREQ(NREQ), .PIPE(PIPE)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .m_clk_en(m_clk_en), .m_in_valid(m_in_valid),
      .m_dataa(m_dataa), .m_datab(m_datab),
      .m_data(m_data), .m_valid(m_valid),
      .busy(busy), .err(err)
   );

   function automatic logic [41:0] mul3(input logic [17:0] a, input logic [23:0] b);
      logic [41:0] p;
      p = '0;
      for (int k = 0; k < 3; k++) p[14*k +: 14] = 14'(a[6*k +: 6]) * 14'(b[8*k +: 8]);
      return p;
   endfunction

   function automatic logic [41:0] pk(input int l0, input int l1, input int l2);
      return {14'(l2), 14'(l1), 14'(l0)};
   endfunction

   // Multiplier model: frozen while m_clk_en is low, cleared by the shared reset.
   logic [PIPE-1:0] mv_q;
   logic [41:0]     md_q [PIPE];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_q <= '0;
         for (int i = 0; i < PIPE; i++) md_q[i] <= '0;
      end else if (m_clk_en) begin
         mv_q    <= {mv_q[PIPE-2:0], m_in_valid};
         md_q[0] <= mul3(m_dataa, m_datab);
         for (int i = 1; i < PIPE; i++) md_q[i] <= md_q[i-1];
      end
   end
   assign m_valid = mv_q[PIPE-1] | force_mv;
   assign m_data  = md_q[PIPE-1];

   always_comb begin
      opb[2] = {16'd0, b2};
      req_a  = '0;
      req_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_a[18*i +: 18] = opa[i];
         req_b[24*i +: 24] = opb[i];
      end
   end

   typedef struct {
      int          seg;
      logic [3:0]  rv;
      logic [3:0]  rr;
      logic [7:0]  b2;
      logic [3:0]  e_rdy;
      logic [3:0]  e_rsp;
      logic        e_en;
      logic        e_busy;
      logic [41:0] e_dat;
   } vec_t;
   vec_t vq[$];

   task automatic add(input int seg, input logic [3:0] rv, input logic [3:0] rr, input logic [7:0] bb,
                      input logic [3:0] e_rdy, input logic [3:0] e_rsp, input logic e_en,
                      input logic e_busy, input logic [41:0] e_dat);
      vec_t v;
      v.seg = seg; v.rv = rv; v.rr = rr; v.b2 = bb; v.e_rdy = e_rdy; v.e_rsp = e_rsp;
      v.e_en = e_en; v.e_busy = e_busy; v.e_dat = e_dat;
      vq.push_back(v);
   endtask

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s (step %0d): got 0x%0h, want 0x%0h", nm, cur, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; force_mv = 1'b0; b2 = 8'd0;
      req_valid = 4'hF; resp_ready = 4'hF;
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_req_ready", 64'(req_ready), 64'h0);
      check("rst_in_valid", 64'(m_in_valid), 64'h0);
      check("rst_clk_en", 64'(m_clk_en), 64'h1);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_err", 64'(err), 64'h0);
      req_valid = 4'h0;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish before 200000");
      $fatal(1);
   end

   initial begin
      logic [41:0] p0, p1, p3;
      int          prev;
      logic [17:0] ea;
      logic [23:0] eb;
      opa[0] = {6'd7, 6'd6, 6'd5};   opb[0] = {8'd4, 8'd3, 8'd2};
      opa[1] = {6'd0, 6'd1, 6'd63};  opb[1] = {8'd7, 8'd10, 8'd255};
      opa[2] = {6'd0, 6'd0, 6'd3};
      opa[3] = {6'd3, 6'd2, 6'd1};   opb[3] = {8'd255, 8'd200, 8'd100};
      p0 = pk(10, 18, 28);
      p1 = pk(16065, 10, 0);
      p3 = pk(100, 400, 765);

      // Round-robin from reset: all requesters active.
      add(1, 4'hF, 4'hF, 9, 4'b0001, 4'b0000, 1, 0, '0);
      add(1, 4'hF, 4'hF, 9, 4'b0010, 4'b0000, 1, 1, '0);
      add(1, 4'hF, 4'hF, 9, 4'b0100, 4'b0000, 1, 1, '0);
      add(1, 4'hF, 4'hF, 9, 4'b1000, 4'b0000, 1, 1, '0);
      add(1, 4'hF, 4'hF, 9, 4'b0001, 4'b0001, 1, 1, p0);
      add(1, 4'hF, 4'hF, 9, 4'b0010, 4'b0010, 1, 1, p1);
      add(1, 4'h0, 4'hF, 9, 4'b0000, 4'b0100, 1, 1, pk(27, 0, 0));
      add(1, 4'h0, 4'hF, 9, 4'b0000, 4'b1000, 1, 1, p3);
      add(1, 4'h0, 4'hF, 9, 4'b0000, 4'b0001, 1, 1, p0);
      add(1, 4'h0, 4'hF, 9, 4'b0000, 4'b0010, 1, 1, p1);
      add(1, 4'h0, 4'hF, 9, 4'b0000, 4'b0000, 1, 0, '0);
      // Single op from requester 1, boundary lane values.
      add(2, 4'b0010, 4'hF, 0, 4'b0010, 4'b0000, 1, 0, '0);
      add(2, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 1, '0);
      add(2, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 1, '0);
      add(2, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 1, '0);
      add(2, 4'b0000, 4'hF, 0, 4'b0000, 4'b0010, 1, 1, pk(16065, 10, 0));
      add(2, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 0, '0);
      // Backpressure on requester 2 for three cycles.
      add(3, 4'b0100, 4'hF,   10, 4'b0100, 4'b0000, 1, 0, '0);
      add(3, 4'b0100, 4'hF,   11, 4'b0100, 4'b0000, 1, 1, '0);
      add(3, 4'b0100, 4'hF,   12, 4'b0100, 4'b0000, 1, 1, '0);
      add(3, 4'b0100, 4'hF,   13, 4'b0100, 4'b0000, 1, 1, '0);
      add(3, 4'b0100, 4'b1011, 14, 4'b0000, 4'b0100, 0, 1, pk(30, 0, 0));
      add(3, 4'b0100, 4'b1011, 14, 4'b0000, 4'b0100, 0, 1, pk(30, 0, 0));
      add(3, 4'b0100, 4'b1011, 14, 4'b0000, 4'b0100, 0, 1, pk(30, 0, 0));
      add(3, 4'b0100, 4'hF,   14, 4'b0100, 4'b0100, 1, 1, pk(30, 0, 0));
      add(3, 4'b0000, 4'hF,   14, 4'b0000, 4'b0100, 1, 1, pk(33, 0, 0));
      add(3, 4'b0000, 4'hF,   14, 4'b0000, 4'b0100, 1, 1, pk(36, 0, 0));
      add(3, 4'b0000, 4'hF,   14, 4'b0000, 4'b0100, 1, 1, pk(39, 0, 0));
      add(3, 4'b0000, 4'hF,   14, 4'b0000, 4'b0100, 1, 1, pk(42, 0, 0));
      add(3, 4'b0000, 4'hF,   14, 4'b0000, 4'b0000, 1, 0, '0);
      // Sparse traffic on requesters 0 and 3, pointer skips idle ones.
      add(4, 4'b0001, 4'hF, 0, 4'b0001, 4'b0000, 1, 0, '0);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 1, '0);
      add(4, 4'b1000, 4'hF, 0, 4'b1000, 4'b0000, 1, 1, '0);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 1, '0);
      add(4, 4'b0001, 4'hF, 0, 4'b0001, 4'b0001, 1, 1, p0);
      add(4, 4'b1001, 4'hF, 0, 4'b1000, 4'b0000, 1, 1, '0);
      add(4, 4'b1001, 4'hF, 0, 4'b0001, 4'b1000, 1, 1, p3);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 1, '0);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b0001, 1, 1, p0);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b1000, 1, 1, p3);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b0001, 1, 1, p0);
      add(4, 4'b0000, 4'hF, 0, 4'b0000, 4'b0000, 1, 0, '0);

      prev = -1;
      foreach (vq[n]) begin
         cur = n;
         if (vq[n].seg != prev) begin
            do_reset();
            step();
            prev = vq[n].seg;
         end
         req_valid  = vq[n].rv;
         resp_ready = vq[n].rr;
         b2         = vq[n].b2;
         #2;
         ea = '0;
         eb = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (vq[n].e_rdy[i]) begin
               ea = opa[i];
               eb = (i == 2) ? {16'd0, vq[n].b2} : opb[i];
            end
         end
         check("req_ready", 64'(req_ready), 64'(vq[n].e_rdy));
         check("resp_valid", 64'(resp_valid), 64'(vq[n].e_rsp));
         check("m_clk_en", 64'(m_clk_en), 64'(vq[n].e_en));
         check("m_in_valid", 64'(m_in_valid), 64'(|vq[n].e_rdy));
         check("busy", 64'(busy), 64'(vq[n].e_busy));
         check("err", 64'(err), 64'h0);
         check("m_dataa", 64'(m_dataa), 64'(ea));
         check("m_datab", 64'(m_datab), 64'(eb));
         if (vq[n].e_rsp != 4'b0000) check("resp_data", 64'(resp_data), 64'(vq[n].e_dat));
         step();
      end

      // Reset with three operations in flight.
      cur = 1000;
      do_reset();
      step();
      req_valid = 4'b0111;
      repeat (3) step();
      req_valid = 4'b0000;
      step();
      #2;
      check("pre_rst_resp", 64'(resp_valid), 64'b0001);
      rst_n = 1'b0;
      #1;
      check("mid_rst_resp", 64'(resp_valid), 64'h0);
      check("mid_rst_busy", 64'(busy), 64'h0);
      check("mid_rst_clk_en", 64'(m_clk_en), 64'h1);
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         cur = 1001 + c;
         #2;
         check("post_rst_resp", 64'(resp_valid), 64'h0);
         check("post_rst_busy", 64'(busy), 64'h0);
         step();
      end
      req_valid = 4'hF;
      #2;
      check("post_rst_ptr", 64'(req_ready), 64'b0001);
      step();
      req_valid = 4'h0;

      // m_valid asserted with an empty pipeline.
      cur = 2000;
      do_reset();
      step();
      force_mv = 1'b1;
      #1;
      check("err_before", 64'(err), 64'h0);
      step();
      force_mv = 1'b0;
      #1;
      check("err_set", 64'(err), 64'h1);
      repeat (3) step();
      check("err_sticky", 64'(err), 64'h1);
      rst_n = 1'b0;
      #1;
      check("err_cleared", 64'(err), 64'h0);
      step();
      rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
